// File: rtl/hd44780_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hd44780_pkg
// Brief    : Shared opcodes, command-word field positions and sequencer
//            state codes for the HD44780 command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package hd44780_pkg;

  // Command opcodes, carried in the top two bits of each RAM word
  localparam logic [1:0] OP_BYTE   = 2'b00;
  localparam logic [1:0] OP_NIBBLE = 2'b01;
  localparam logic [1:0] OP_DELAY  = 2'b10;
  localparam logic [1:0] OP_END    = 2'b11;

  // Command word field positions
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 14;
  localparam int RS_BIT    = 8;
  localparam int DLY_MSB   = 13;
  localparam int DLY_WIDTH = DLY_MSB + 1;

  // Sequencer state codes
  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] S_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] S_FETCH_A = 4'd1;
  localparam logic [STATE_W-1:0] S_FETCH_W = 4'd2;
  localparam logic [STATE_W-1:0] S_DECODE  = 4'd3;
  localparam logic [STATE_W-1:0] S_SETUP   = 4'd4;
  localparam logic [STATE_W-1:0] S_EHI     = 4'd5;
  localparam logic [STATE_W-1:0] S_ELO     = 4'd6;
  localparam logic [STATE_W-1:0] S_BWAIT   = 4'd7;
  localparam logic [STATE_W-1:0] S_DLY     = 4'd8;
  localparam logic [STATE_W-1:0] S_NEXT    = 4'd9;

  // Extract the opcode field of a command word
  function automatic logic [1:0] cmd_op(input logic [15:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage : hd44780_pkg
`default_nettype wire

// File: rtl/hd44780_timer.sv
`default_nettype none
// ============================================================================
// Module   : hd44780_timer
// Brief    : Loadable down-counter. Load has priority over decrement; the
//            count saturates at zero and `zero` flags the terminal value.
// Revision : 1.0 - initial release
// ============================================================================
module hd44780_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: reload, or step down towards zero when enabled
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule : hd44780_timer
`default_nettype wire

// File: rtl/hd44780_seq.sv
`default_nettype none
// ============================================================================
// Module   : hd44780_seq
// Brief    : Fetches 16-bit command words from the command RAM and plays
//            them out on a 4-bit HD44780 bus with setup, enable-pulse and
//            execution-wait timing. Reports busy/done to the host.
// Revision : 1.0 - initial release
// ============================================================================
module hd44780_seq
  import hd44780_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 12,
  parameter int NIBBLE_GAP    = 12,
  parameter int BYTE_WAIT     = 600,
  parameter int TICK_CYCLES   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [15:0]           rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  lcd_rs,
  output logic                  lcd_e,
  output logic                  lcd_rw,
  output logic [3:0]            lcd_db
);

  // Both timers share one width, large enough for the longest byte wait and
  // for a full 14-bit delay count expressed in ticks.
  localparam int DLY_MAX = (1 << DLY_WIDTH) * TICK_CYCLES;
  localparam int CNT_MAX = (BYTE_WAIT > DLY_MAX) ? BYTE_WAIT : DLY_MAX;
  localparam int TW      = $clog2(CNT_MAX + 1);

  localparam logic [TW-1:0] c_setup_ld = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] c_ehi_ld   = TW'(E_HIGH_CYCLES - 1);
  localparam logic [TW-1:0] c_gap_ld   = TW'(NIBBLE_GAP - 1);
  localparam logic [TW-1:0] c_bwait_ld = TW'(BYTE_WAIT - 1);
  localparam logic [TW-1:0] c_tick_ld  = TW'(TICK_CYCLES - 1);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [15:0]           cmd_q, cmd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rs_q, rs_d;
  logic                  e_q, e_d;
  logic [3:0]            db_q, db_d;
  logic                  pend_q, pend_d;   // low nibble of a BYTE still to send

  logic          ph_load, ph_en, ph_zero;
  logic [TW-1:0] ph_value;
  logic          pre_load, pre_en, pre_zero;
  logic [TW-1:0] pre_value;

  // Phase timer: cycles spent in SETUP/EHI/ELO/BWAIT, or remaining delay ticks
  hd44780_timer #(
    .WIDTH (TW)
  ) u_phase_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ph_load),
    .value (ph_value),
    .en    (ph_en),
    .zero  (ph_zero)
  );

  // Tick prescaler: divides the clock down to delay ticks
  hd44780_timer #(
    .WIDTH (TW)
  ) u_tick_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pre_load),
    .value (pre_value),
    .en    (pre_en),
    .zero  (pre_zero)
  );

  // Sequencer next-state, timer control and LCD pin update logic
  always_comb begin
    state_d   = state_q;
    raddr_d   = raddr_q;
    cmd_d     = cmd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rs_d      = rs_q;
    db_d      = db_q;
    pend_d    = pend_q;
    ph_load   = 1'b0;
    ph_value  = '0;
    ph_en     = 1'b0;
    pre_load  = 1'b0;
    pre_value = '0;
    pre_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          raddr_d = start_addr;
          busy_d  = 1'b1;
          state_d = S_FETCH_A;
        end
      end

      // RAM samples raddr at the end of this cycle
      S_FETCH_A: state_d = S_FETCH_W;

      S_FETCH_W: begin
        cmd_d   = rdata;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        case (cmd_op(cmd_q))
          OP_BYTE: begin
            rs_d     = cmd_q[RS_BIT];
            db_d     = cmd_q[7:4];
            pend_d   = 1'b1;
            ph_load  = 1'b1;
            ph_value = c_setup_ld;
            state_d  = S_SETUP;
          end
          OP_NIBBLE: begin
            rs_d     = cmd_q[RS_BIT];
            db_d     = cmd_q[3:0];
            pend_d   = 1'b0;
            ph_load  = 1'b1;
            ph_value = c_setup_ld;
            state_d  = S_SETUP;
          end
          OP_DELAY: begin
            // Phase timer counts remaining ticks; prescaler counts cycles per tick
            ph_load   = 1'b1;
            ph_value  = TW'(cmd_q[DLY_MSB:0]) - TW'(1);
            pre_load  = 1'b1;
            pre_value = c_tick_ld;
            state_d   = (cmd_q[DLY_MSB:0] == '0) ? S_NEXT : S_DLY;
          end
          OP_END: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        endcase
      end

      S_SETUP: begin
        if (ph_zero) begin
          ph_load  = 1'b1;
          ph_value = c_ehi_ld;
          state_d  = S_EHI;
        end else begin
          ph_en = 1'b1;
        end
      end

      S_EHI: begin
        if (ph_zero) begin
          ph_load  = 1'b1;
          ph_value = c_gap_ld;
          state_d  = S_ELO;
        end else begin
          ph_en = 1'b1;
        end
      end

      S_ELO: begin
        if (ph_zero) begin
          ph_load = 1'b1;
          if (pend_q) begin
            // Data only changes on SETUP entry, with E already low
            pend_d   = 1'b0;
            db_d     = cmd_q[3:0];
            ph_value = c_setup_ld;
            state_d  = S_SETUP;
          end else begin
            ph_value = c_bwait_ld;
            state_d  = S_BWAIT;
          end
        end else begin
          ph_en = 1'b1;
        end
      end

      S_BWAIT: begin
        if (ph_zero) begin
          state_d = S_NEXT;
        end else begin
          ph_en = 1'b1;
        end
      end

      S_DLY: begin
        if (pre_zero) begin
          if (ph_zero) begin
            state_d = S_NEXT;
          end else begin
            ph_en     = 1'b1;
            pre_load  = 1'b1;
            pre_value = c_tick_ld;
          end
        end else begin
          pre_en = 1'b1;
        end
      end

      // Address wraps silently at the top of the RAM
      S_NEXT: begin
        raddr_d = raddr_q + ADDR_WIDTH'(1);
        state_d = S_FETCH_A;
      end

      default: state_d = S_IDLE;
    endcase

    // E is registered and high exactly while the sequencer sits in EHI
    e_d = (state_d == S_EHI);
  end

  // State and output registers; reset drops E and aborts any command at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      cmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      db_q    <= 4'h0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      db_q    <= db_d;
      pend_q  <= pend_d;
    end
  end

  assign raddr  = raddr_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign lcd_rs = rs_q;
  assign lcd_e  = e_q;
  assign lcd_rw = 1'b0;
  assign lcd_db = db_q;

endmodule : hd44780_seq
`default_nettype wire

// File: tb/tb_hd44780_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_hd44780_seq
// Brief    : Self-checking bench for hd44780_seq. A command-level model
//            predicts every E pulse and done pulse; the monitor compares
//            them against the DUT as they occur.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hd44780_seq;

  localparam int SU   = 1;
  localparam int EH   = 2;
  localparam int GAP  = 2;
  localparam int BW   = 4;
  localparam int TICK = 3;
  localparam int P    = SU + EH + GAP;

  typedef struct {
    bit       is_done;
    bit       rs;
    bit [3:0] db;
    int       t;
  } ev_t;

  ev_t exp_q[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 1: 8-bit address
  logic        start1 = 1'b0;
  logic [7:0]  start_addr1 = '0;
  logic [7:0]  raddr1;
  logic [15:0] rdata1;
  logic        busy1, done1, lcd_rs1, lcd_e1, lcd_rw1;
  logic [3:0]  lcd_db1;
  logic [15:0] mem1 [256];

  // DUT 2: 2-bit address, used for wrap-around
  logic        start2 = 1'b0;
  logic [1:0]  start_addr2 = '0;
  logic [1:0]  raddr2;
  logic [15:0] rdata2;
  logic        busy2, done2, lcd_rs2, lcd_e2, lcd_rw2;
  logic [3:0]  lcd_db2;
  logic [15:0] mem2 [4];

  always @(posedge clk) rdata1 <= mem1[raddr1];
  always @(posedge clk) rdata2 <= mem2[raddr2];

  hd44780_seq #(
    .ADDR_WIDTH(8), .SETUP_CYCLES(SU), .E_HIGH_CYCLES(EH),
    .NIBBLE_GAP(GAP), .BYTE_WAIT(BW), .TICK_CYCLES(TICK)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .start_addr(start_addr1),
    .raddr(raddr1), .rdata(rdata1), .busy(busy1), .done(done1),
    .lcd_rs(lcd_rs1), .lcd_e(lcd_e1), .lcd_rw(lcd_rw1), .lcd_db(lcd_db1)
  );

  hd44780_seq #(
    .ADDR_WIDTH(2), .SETUP_CYCLES(SU), .E_HIGH_CYCLES(EH),
    .NIBBLE_GAP(GAP), .BYTE_WAIT(BW), .TICK_CYCLES(TICK)
  ) u_dut_w (
    .clk(clk), .rst_n(rst_n), .start(start2), .start_addr(start_addr2),
    .raddr(raddr2), .rdata(rdata2), .busy(busy2), .done(done2),
    .lcd_rs(lcd_rs2), .lcd_e(lcd_e2), .lcd_rw(lcd_rw2), .lcd_db(lcd_db2)
  );

  // Monitor watches whichever DUT is selected
  bit         sel = 1'b0;
  logic       m_e, m_rs, m_done, m_busy, m_rw;
  logic [3:0] m_db;
  assign m_e    = sel ? lcd_e2  : lcd_e1;
  assign m_rs   = sel ? lcd_rs2 : lcd_rs1;
  assign m_db   = sel ? lcd_db2 : lcd_db1;
  assign m_done = sel ? done2   : done1;
  assign m_busy = sel ? busy2   : busy1;
  assign m_rw   = sel ? lcd_rw2 : lcd_rw1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int t0 = 0;
  int exp_done_t = 0;
  bit mon_en = 1'b1;
  bit done_seen = 1'b0;
  bit e_prev = 1'b0;
  int rise_t = 0;
  logic [3:0] rise_db = '0;
  logic rise_rs = 1'b0;

  // Scoreboard monitor: each E rise and each done pulse consumes one expectation
  always @(negedge clk) begin
    int  rel;
    ev_t ev;
    rel = cyc - t0;
    if (mon_en && rst_n) begin
      if (m_e && !e_prev) begin
        chk("e_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          chk("e_kind", 32'(ev.is_done), 0);
          chk("e_time", rel, ev.t);
          chk("e_rs", 32'(m_rs), 32'(ev.rs));
          chk("e_db", 32'(m_db), 32'(ev.db));
        end
        rise_t = rel; rise_db = m_db; rise_rs = m_rs;
      end
      if (!m_e && e_prev) begin
        chk("e_width", rel - rise_t, EH);
        chk("db_held", 32'(m_db), 32'(rise_db));
        chk("rs_held", 32'(m_rs), 32'(rise_rs));
      end
      if (m_done) begin
        chk("done_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          chk("done_kind", 32'(ev.is_done), 1);
          chk("done_time", rel, ev.t);
        end
        chk("busy_at_done", 32'(m_busy), 0);
        chk("rw_low", 32'(m_rw), 0);
        done_seen = 1'b1;
      end
      e_prev = m_e;
    end
  end

  // Command-level model: walk RAM from addr, predicting event times relative to start
  task automatic build_expect(input bit which, input int addr);
    int t = 0;
    int a = addr;
    logic [15:0] w;
    ev_t ev;
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      w = which ? mem2[a % 4] : mem1[a % 256];
      case (w[15:14])
        2'b00: begin
          ev = '{0, w[8], w[7:4], t + 3 + SU};      exp_q.push_back(ev);
          ev = '{0, w[8], w[3:0], t + 3 + P + SU};  exp_q.push_back(ev);
          t += 3 + 2 * P + BW + 1;
        end
        2'b01: begin
          ev = '{0, w[8], w[3:0], t + 3 + SU};      exp_q.push_back(ev);
          t += 3 + P + BW + 1;
        end
        2'b10: t += 3 + int'(w[13:0]) * TICK + 1;
        default: begin
          ev = '{1, 0, 4'h0, t + 3};                exp_q.push_back(ev);
          exp_done_t = t + 3;
          return;
        end
      endcase
      a = (a + 1) % (which ? 4 : 256);
    end
  endtask

  // Start a sequence, optionally fire a second start at cycle inject_at while busy
  task automatic run_seq(input bit which, input int addr, input int inject_at);
    build_expect(which, addr);
    sel = which;
    done_seen = 1'b0;
    @(negedge clk);
    if (which) begin start2 = 1'b1; start_addr2 = 2'(addr); end
    else       begin start1 = 1'b1; start_addr1 = 8'(addr); end
    t0 = cyc + 1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    for (int k = 0; k < exp_done_t + 20 && !done_seen; k++) begin
      if (k == inject_at) begin start1 = 1'b1; start_addr1 = 8'd7; end
      else start1 = 1'b0;
      @(negedge clk);
    end
    start1 = 1'b0;
    chk("done_seen", 32'(done_seen), 1);
    repeat (3) @(negedge clk);
    chk("q_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem1[i] = 16'hC000;
    for (int i = 0; i < 4; i++)   mem2[i] = 16'hC000;

    // Reset state
    #1;
    chk("rst_raddr", 32'(raddr1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_e", 32'(lcd_e1), 0);
    chk("rst_rs", 32'(lcd_rs1), 0);
    chk("rst_rw", 32'(lcd_rw1), 0);
    chk("rst_db", 32'(lcd_db1), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Byte 0x28 then END
    mem1[0] = 16'h0128; mem1[1] = 16'hC000;
    run_seq(0, 0, -1);

    // Init-style nibbles 3,3,2 then END
    mem1[0] = 16'h4003; mem1[1] = 16'h4003; mem1[2] = 16'h4002; mem1[3] = 16'hC000;
    run_seq(0, 0, -1);

    // Delay of 5 ticks then END, no E activity
    mem1[5] = 16'h8005; mem1[6] = 16'hC000;
    run_seq(0, 5, -1);

    // Zero delay, RS=1 byte, then END
    mem1[10] = 16'h8000; mem1[11] = 16'h01A5; mem1[12] = 16'hC000;
    run_seq(0, 10, -1);

    // Address wrap on the 2-bit instance
    mem2[3] = 16'h0141; mem2[0] = 16'hC000;
    run_seq(1, 3, -1);
    chk("wrap_raddr", 32'(raddr2), 0);

    // Start while busy must be ignored
    mem1[0] = 16'h0128; mem1[1] = 16'hC000; mem1[7] = 16'h4005; mem1[8] = 16'hC000;
    run_seq(0, 0, 5);

    // Reset in the middle of an E-high phase
    build_expect(0, 0);
    sel = 1'b0;
    @(negedge clk);
    start1 = 1'b1; start_addr1 = 8'd0; t0 = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 20 && !lcd_e1; k++) @(negedge clk);
    chk("ehi_reached", 32'(lcd_e1), 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_e", 32'(lcd_e1), 0);
    chk("arst_busy", 32'(busy1), 0);
    chk("arst_raddr", 32'(raddr1), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    e_prev = 1'b0;
    mon_en = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_resume_busy", 32'(busy1), 0);
    chk("no_resume_e", 32'(lcd_e1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hd44780_seq
`default_nettype wire
